video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
//  Parametrised raster timing generator; replaces the fixed 1024x768@60 generator.
//  Produces pixel/line counters, syncs, blank and data-enable for any VESA-style mode.
//  Adds a pixel clock-enable, configurable sync polarity, line/frame start strobes
//  and an optional line-compare strobe. Drives the pixel pipeline and the VGA pins.
// PARAMETERS
//  H_ACTIVE   1024  visible pixels per line
//  H_FP       24    horizontal front porch (pixels)
//  H_SYNC     136   hsync width (pixels)
//  H_BP       160   horizontal back porch; H_TOTAL = sum of H_* = 1344
//  V_ACTIVE   768   visible lines per frame
//  V_FP       3     vertical front porch (lines)
//  V_SYNC     6     vsync width (lines)
//  V_BP       29    vertical back porch; V_TOTAL = sum of V_* = 806
//  HSYNC_POL  0     0 = hsync active-low, 1 = active-high
//  VSYNC_POL  0     0 = vsync active-low, 1 = active-high
//  HW         11    hcount width; H_TOTAL-1 must fit in HW bits
//  VW         10    vcount width; V_TOTAL-1 must fit in VW bits
// PORTS
//  vclock      in   1   pixel-domain clock
//  reset       in   1   synchronous, active-high reset
//  ce          in   1   pixel enable; timing advances only on cycles with ce=1
//  match_line  in   VW  line number for line_match (used only with VTG_LINE_MATCH_EN)
//  hcount      out  HW  current pixel in line, 0..H_TOTAL-1
//  vcount      out  VW  current line in frame, 0..V_TOTAL-1
//  hsync       out  1   horizontal sync, polarity per HSYNC_POL
//  vsync       out  1   vertical sync, polarity per VSYNC_POL
//  blank       out  1   1 outside the active region
//  de          out  1   data enable, always ~blank
//  line_start  out  1   1-cycle strobe when hcount wraps to 0
//  frame_start out  1   1-cycle strobe when (hcount,vcount) wraps to (0,0)
//  line_match  out  1   1-cycle strobe entering (0,match_line); always 0 without macro
// BEHAVIOUR
//  - One clock (vclock). Reset is synchronous, active-high. All outputs are registered.
//  - All outputs describe the same position: hsync/vsync/blank/de always match the
//    hcount/vcount presented in that cycle (zero skew; decode from next-state values).
//  - Reset (also mid-frame): hcount=0, vcount=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL,
//    blank=0, de=1, all strobes 0. No frame_start for the first frame after reset.
//  - ce=1: hcount increments; at H_TOTAL-1 it wraps to 0 and vcount increments;
//    at vcount=V_TOTAL-1 it wraps to 0. ce=0: counters, syncs and blank hold;
//    strobes forced to 0, so each strobe is exactly one vclock wide.
//  - Active when hcount<H_ACTIVE and vcount<V_ACTIVE; blank = ~active.
//  - hsync active for H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, any line.
//  - vsync active for V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC; changes only
//    together with a vcount change (at hcount=0).
//  - line_start=1 in the cycle hcount becomes 0 via wrap; frame_start=1 in the cycle
//    both wrap to 0 (line_start is also 1 then).
//  - Non-ce cycles add no latency: the update is visible the cycle after the ce edge.
// CONFIGURATION
//  VTG_LINE_MATCH_EN defined: match_line is sampled when hcount wraps; line_match=1
//    in the cycle the counters enter (0, match_line). match_line >= V_TOTAL never fires.
//  Not defined: no compare logic; line_match tied to 0; match_line ignored.
// TESTING
//  1 Reset held 3 cycles, ce=1 -> hcount=0, vcount=0, hsync=1, vsync=1, blank=0, de=1.
//  2 Run 1 line -> blank 0 at hcount 1023, 1 at 1024; hsync=0 for 1048..1183;
//    after 1343: hcount=0, vcount=1, line_start 1 cycle.
//  3 Run full frame -> blank=1 from vcount 768; vsync=0 for lines 771..776;
//    after (1343,805): (0,0), frame_start 1 cycle; period 1344*806 = 1083264 clocks.
//  4 ce toggled 1,0,1,0 -> line lasts 2688 vclocks; strobes stay 1 cycle wide.
//  5 HSYNC_POL=1, VSYNC_POL=1 -> hsync=1 only at 1048..1183, vsync=1 only at 771..776.
//  6 Reset at (500,300) -> next cycle (0,0) with reset values; with VTG_LINE_MATCH_EN,
//    match_line=100 -> line_match 1 cycle at (0,100) only; undefined -> never 1.

Source files
------------

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: pixel/line counters, syncs, blank, de and strobes.
// Optional line-compare strobe enabled by defining VTG_LINE_MATCH_EN.
module video_timing_gen #(
  parameter int H_ACTIVE  = 1024,
  parameter int H_FP      = 24,
  parameter int H_SYNC    = 136,
  parameter int H_BP      = 160,
  parameter int V_ACTIVE  = 768,
  parameter int V_FP      = 3,
  parameter int V_SYNC    = 6,
  parameter int V_BP      = 29,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int HW        = 11,
  parameter int VW        = 10
) (
  input  logic          vclock,
  input  logic          reset,
  input  logic          ce,
  input  logic [VW-1:0] match_line,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          blank,
  output logic          de,
  output logic          line_start,
  output logic          frame_start,
  output logic          line_match
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HX = HW + 1;
  localparam int VX = VW + 1;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  // Thresholds carry one extra bit so a sync ending exactly at the total still fits.
  localparam logic [HX-1:0] H_ACT_END  = HX'(H_ACTIVE);
  localparam logic [HX-1:0] H_SYNC_BEG = HX'(H_ACTIVE + H_FP);
  localparam logic [HX-1:0] H_SYNC_END = HX'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VX-1:0] V_ACT_END  = VX'(V_ACTIVE);
  localparam logic [VX-1:0] V_SYNC_BEG = VX'(V_ACTIVE + V_FP);
  localparam logic [VX-1:0] V_SYNC_END = VX'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] r_hcount;
  logic [VW-1:0] r_vcount;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_blank;
  logic          r_line_start;
  logic          r_frame_start;

  logic          w_h_wrap;
  logic          w_v_wrap;
  logic [HW-1:0] w_h_next;
  logic [VW-1:0] w_v_next;
  logic [HX-1:0] w_hx;
  logic [VX-1:0] w_vx;
  logic          w_active;
  logic          w_hs_on;
  logic          w_vs_on;

  assign w_h_wrap = (r_hcount == H_LAST);
  assign w_v_wrap = (r_vcount == V_LAST);
  assign w_h_next = w_h_wrap ? '0 : r_hcount + 1'b1;
  assign w_v_next = w_h_wrap ? (w_v_wrap ? '0 : r_vcount + 1'b1) : r_vcount;

  // Decode from the next position so every output matches the counters it is registered with.
  assign w_hx     = {1'b0, w_h_next};
  assign w_vx     = {1'b0, w_v_next};
  assign w_active = (w_hx < H_ACT_END) && (w_vx < V_ACT_END);
  assign w_hs_on  = (w_hx >= H_SYNC_BEG) && (w_hx < H_SYNC_END);
  assign w_vs_on  = (w_vx >= V_SYNC_BEG) && (w_vx < V_SYNC_END);

  always_ff @(posedge vclock) begin
    if (reset) begin
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_hsync       <= ~HSYNC_POL;
      r_vsync       <= ~VSYNC_POL;
      r_blank       <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (ce) begin
      r_hcount      <= w_h_next;
      r_vcount      <= w_v_next;
      r_hsync       <= w_hs_on ? HSYNC_POL : ~HSYNC_POL;
      r_vsync       <= w_vs_on ? VSYNC_POL : ~VSYNC_POL;
      r_blank       <= ~w_active;
      r_line_start  <= w_h_wrap;
      r_frame_start <= w_h_wrap && w_v_wrap;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

`ifdef VTG_LINE_MATCH_EN
  logic r_line_match;

  always_ff @(posedge vclock) begin
    if (reset) begin
      r_line_match <= 1'b0;
    end else if (ce) begin
      r_line_match <= w_h_wrap && (w_v_next == match_line);
    end else begin
      r_line_match <= 1'b0;
    end
  end

  assign line_match = r_line_match;
`else
  logic w_unused_match_line;
  assign w_unused_match_line = ^match_line;
  assign line_match = 1'b0;
`endif

  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign blank       = r_blank;
  assign de          = ~r_blank;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a small-mode DUT checked by a scoreboard against a
// linear-position model, plus a default-mode DUT checked over its first line.
module tb_video_timing_gen;

  // Small mode keeps full frames short.
  localparam int HA = 10, HF = 2, HS = 3, HB = 4;
  localparam int VA = 5,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;   // 19
  localparam int VT = VA + VF + VS + VB;   // 10
  localparam int FR = HT * VT;             // 190
  localparam int HW = 5, VW = 4;
  localparam int W  = HW + VW + 7;

  logic          vclock = 1'b0;
  logic          reset  = 1'b1;
  logic          ce     = 1'b0;
  logic [VW-1:0] match_line = '0;

  logic [HW-1:0] hcount;
  logic [VW-1:0] vcount;
  logic hsync, vsync, blank, de, line_start, frame_start, line_match;

  int n_chk = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  always #5 vclock = ~vclock;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .HW(HW), .VW(VW)
  ) u_dut (
    .vclock(vclock), .reset(reset), .ce(ce), .match_line(match_line),
    .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
    .blank(blank), .de(de), .line_start(line_start),
    .frame_start(frame_start), .line_match(line_match)
  );

  // Default 1024x768 mode, free-running.
  logic        d_reset = 1'b1;
  logic        d_ce    = 1'b1;
  logic [9:0]  d_match = 10'd0;
  logic [10:0] d_hcount;
  logic [9:0]  d_vcount;
  logic d_hsync, d_vsync, d_blank, d_de, d_line_start, d_frame_start, d_line_match;

  video_timing_gen u_dflt (
    .vclock(vclock), .reset(d_reset), .ce(d_ce), .match_line(d_match),
    .hcount(d_hcount), .vcount(d_vcount), .hsync(d_hsync), .vsync(d_vsync),
    .blank(d_blank), .de(d_de), .line_start(d_line_start),
    .frame_start(d_frame_start), .line_match(d_line_match)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
    end
  endtask

  // Reference model: position is a single index into the frame.
  int m_p = 0;

  function automatic logic [W-1:0] model_out(input int p, input bit ls, input bit fs, input bit lm);
    int h, v;
    bit act, hs_on, vs_on;
    h     = p % HT;
    v     = p / HT;
    act   = (h < HA) && (v < VA);
    hs_on = (h >= HA + HF) && (h < HA + HF + HS);
    vs_on = (v >= VA + VF) && (v < VA + VF + VS);
    return {HW'(h), VW'(v), hs_on, vs_on, !act, act, ls, fs, lm};
  endfunction

  task automatic drive_cycle(input bit rst, input bit ce_v, input logic [VW-1:0] ml);
    bit ls, fs, lm;
    @(negedge vclock);
    reset      = rst;
    ce         = ce_v;
    match_line = ml;
    ls = 1'b0; fs = 1'b0; lm = 1'b0;
    if (rst) begin
      m_p = 0;
    end else if (ce_v) begin
      m_p = (m_p + 1) % FR;
      ls  = (m_p % HT) == 0;
      fs  = (m_p == 0);
`ifdef VTG_LINE_MATCH_EN
      lm  = ls && ((m_p / HT) == int'(ml));
`endif
    end
    exp_q.push_back(model_out(m_p, ls, fs, lm));
  endtask

  // Monitor: every clock the small DUT presents one registered output vector.
  always @(posedge vclock) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [W-1:0] exp_v;
      exp_v = exp_q.pop_front();
      chk("small_dut_outputs",
          32'({hcount, vcount, hsync, vsync, blank, de, line_start, frame_start, line_match}),
          32'(exp_v));
    end
  end

  task automatic run_small();
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, 4'd3);
    for (int i = 0; i < 2 * FR + 20; i++) drive_cycle(1'b0, 1'b1, 4'd3);
    for (int i = 0; i < 800; i++)
      drive_cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1),
                  VW'($urandom_range(0, 15)));
    // Reset mid-frame, then alternate ce so each line takes two clocks per pixel.
    while (m_p < 3 * HT) drive_cycle(1'b0, 1'b1, 4'd2);
    drive_cycle(1'b1, 1'b1, 4'd2);
    for (int i = 0; i < 2 * FR + 10; i++) drive_cycle(1'b0, (i % 2) == 0, 4'd2);
    // Out-of-range match lines.
    for (int i = 0; i < FR + 5; i++) drive_cycle(1'b0, 1'b1, VW'($urandom_range(VT, 15)));
    drive_cycle(1'b0, 1'b0, 4'd0);
  endtask

  task automatic run_default();
    int h, v;
    repeat (3) @(posedge vclock);
    #1;
    chk("dflt_reset_hcount", 32'(d_hcount), 32'd0);
    chk("dflt_reset_vcount", 32'(d_vcount), 32'd0);
    chk("dflt_reset_hsync",  32'(d_hsync),  32'd1);
    chk("dflt_reset_vsync",  32'(d_vsync),  32'd1);
    chk("dflt_reset_blank",  32'(d_blank),  32'd0);
    chk("dflt_reset_de",     32'(d_de),     32'd1);
    @(negedge vclock);
    d_reset = 1'b0;
    for (int k = 1; k <= 1400; k++) begin
      @(posedge vclock);
      #1;
      h = k % 1344;
      v = k / 1344;
      chk("dflt_hcount", 32'(d_hcount), 32'(h));
      chk("dflt_vcount", 32'(d_vcount), 32'(v));
      chk("dflt_blank",  32'(d_blank),  32'(h >= 1024));
      chk("dflt_hsync",  32'(d_hsync),  32'(!(h >= 1048 && h < 1184)));
      chk("dflt_vsync",  32'(d_vsync),  32'd1);
      chk("dflt_line_start",  32'(d_line_start),  32'(h == 0));
      chk("dflt_frame_start", 32'(d_frame_start), 32'd0);
      chk("dflt_line_match",  32'(d_line_match),  32'd0);
    end
  endtask

  initial begin
    fork
      run_small();
      run_default();
    join
    repeat (3) @(posedge vclock);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
